// File: rtl/vedic_pkg.sv
// Shared definitions for the sequential Vedic multiplier: FSM state
// encoding, nibble/partial-product widths and the 2x2 Urdhva-Tiryak cell.
package vedic_pkg;

  localparam int unsigned NIB_W = 4;
  localparam int unsigned PP_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // 2x2 vertically-and-crosswise product: vertical LSB, crosswise middle,
  // vertical MSB plus the crosswise carry.
  function automatic logic [3:0] vedic2x2(input logic [1:0] x, input logic [1:0] y);
    logic t1, t2, s1, c1, v;
    t1 = x[1] & y[0];
    t2 = x[0] & y[1];
    s1 = t1 ^ t2;
    c1 = t1 & t2;
    v  = x[1] & y[1];
    return {v & c1, v ^ c1, s1, x[0] & y[0]};
  endfunction

endpackage

// File: rtl/mul4x4.sv
// Combinational 4x4 Vedic multiplier built from four 2x2 Urdhva-Tiryak cells.
module mul4x4
  import vedic_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  output logic [PP_W-1:0]  p
);

  logic [3:0] q0, q1, q2, q3;
  logic [4:0] mid;

  // Combine the four 2x2 partial products with their 2-bit weights.
  always_comb begin
    q0  = vedic2x2(a[1:0], b[1:0]);
    q1  = vedic2x2(a[3:2], b[1:0]);
    q2  = vedic2x2(a[1:0], b[3:2]);
    q3  = vedic2x2(a[3:2], b[3:2]);
    mid = {1'b0, q1} + {1'b0, q2};
    p   = {4'b0000, q0} + {1'b0, mid, 2'b00} + {q3, 4'b0000};
  end

endmodule

// File: rtl/vedic_seq_mul.sv
// Iterative WIDTH x WIDTH unsigned multiplier: one nibble pair per cycle
// through a single mul4x4 core, shift-accumulated into a 2*WIDTH product.
// Optional two's-complement mode behind macro VEDIC_SEQ_MUL_SIGNED_EN
// (adds port signed_op; operands are captured as magnitudes plus a sign).
module vedic_seq_mul
  import vedic_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
`ifdef VEDIC_SEQ_MUL_SIGNED_EN
  ,
  input  logic               signed_op
`endif
);

  localparam int unsigned N   = WIDTH / NIB_W;
  localparam int unsigned CW  = $clog2(N);
  localparam int unsigned PW  = 2 * WIDTH;
  localparam int unsigned SHW = $clog2(PW);

  state_t             state;
  logic [WIDTH-1:0]   a_r, b_r;
  logic [WIDTH-1:0]   a_cap, b_cap;
  logic [PW-1:0]      acc, acc_next, pp_sh, res;
  logic [CW-1:0]      i, j;
  logic [NIB_W-1:0]   a_nib, b_nib;
  logic [PP_W-1:0]    pp;
  logic [SHW-1:0]     shamt;
`ifdef VEDIC_SEQ_MUL_SIGNED_EN
  logic               sign_r, sign_cap;
`endif

  // Select the current nibble pair from the registered operands.
  always_comb begin
    a_nib = a_r[NIB_W*i +: NIB_W];
    b_nib = b_r[NIB_W*j +: NIB_W];
  end

  mul4x4 u_core (
    .a (a_nib),
    .b (b_nib),
    .p (pp)
  );

  // Weight the nibble product by 4*(i+j) and add it to the running sum.
  always_comb begin
    shamt    = SHW'((32'(i) + 32'(j)) * NIB_W);
    pp_sh    = PW'(pp) << shamt;
    acc_next = acc + pp_sh;
    res      = acc_next;
`ifdef VEDIC_SEQ_MUL_SIGNED_EN
    if (sign_r) res = '0 - acc_next;
`endif
  end

  // Operand capture values; in signed mode these are magnitudes.
  always_comb begin
    a_cap = a;
    b_cap = b;
`ifdef VEDIC_SEQ_MUL_SIGNED_EN
    sign_cap = 1'b0;
    if (signed_op) begin
      if (a[WIDTH-1]) a_cap = '0 - a;
      if (b[WIDTH-1]) b_cap = '0 - b;
      sign_cap = a[WIDTH-1] ^ b[WIDTH-1];
    end
`endif
  end

  // Control FSM with registered handshake outputs, counters and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      p         <= '0;
      acc       <= '0;
      a_r       <= '0;
      b_r       <= '0;
      i         <= '0;
      j         <= '0;
`ifdef VEDIC_SEQ_MUL_SIGNED_EN
      sign_r    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a_cap;
            b_r      <= b_cap;
`ifdef VEDIC_SEQ_MUL_SIGNED_EN
            sign_r   <= sign_cap;
`endif
            acc      <= '0;
            i        <= '0;
            j        <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          acc <= acc_next;
          if (j == CW'(N - 1)) begin
            j <= '0;
            if (i == CW'(N - 1)) begin
              i         <= '0;
              p         <= res;
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              i <= i + 1'b1;
            end
          end else begin
            j <= j + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vedic_seq_mul.sv
// Self-checking bench for vedic_seq_mul (WIDTH=16): table-driven products,
// stall/latency/handshake checks, mid-run reset, continuous in_valid and
// randomised transactions. Signed cases are built when
// VEDIC_SEQ_MUL_SIGNED_EN is defined.
module tb_vedic_seq_mul;

  localparam int unsigned W  = 16;
  localparam int unsigned NN = (W / 4) * (W / 4);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic           in_ready, out_valid, busy;
  logic [W-1:0]   a = '0, b = '0;
  logic [2*W-1:0] p;
`ifdef VEDIC_SEQ_MUL_SIGNED_EN
  logic           signed_op = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  logic [2*W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] expv;
    int unsigned    stall;
    bit             early;
    bit             sgn;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  vedic_seq_mul #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
`ifdef VEDIC_SEQ_MUL_SIGNED_EN
    ,
    .signed_op (signed_op)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, expv);
    end
  endtask

  function automatic logic [2*W-1:0] umul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] xe, ye;
    xe = {{W{1'b0}}, x};
    ye = {{W{1'b0}}, y};
    return xe * ye;
  endfunction

  function automatic logic [2*W-1:0] smul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] xe, ye;
    xe = {{W{x[W-1]}}, x};
    ye = {{W{y[W-1]}}, y};
    return xe * ye;
  endfunction

  // Called just after a rising edge with the DUT in IDLE; returns likewise.
  task automatic txn(input vec_t v);
    int unsigned    cyc;
    bit             bad_ctl;
    logic [2*W-1:0] want;
    a        = v.a;
    b        = v.b;
    in_valid = 1'b1;
`ifdef VEDIC_SEQ_MUL_SIGNED_EN
    signed_op = v.sgn;
`endif
    cyc = 0;
    @(negedge clk);
    while (!in_ready && cyc < 100) begin
      @(posedge clk); #1; cyc++; @(negedge clk);
    end
    chk("accept_ready", in_ready, 1'b1);
    exp_q.push_back(v.expv);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
`ifdef VEDIC_SEQ_MUL_SIGNED_EN
    signed_op = ~v.sgn;
`endif
    if (v.early) out_ready = 1'b1;
    cyc = 0;
    bad_ctl = 1'b0;
    @(negedge clk);
    while (!out_valid && cyc < 200) begin
      if (in_ready || !busy) bad_ctl = 1'b1;
      @(posedge clk); #1; cyc++; @(negedge clk);
    end
    chk("latency", cyc, NN);
    chk("run_ctl", bad_ctl, 1'b0);
    if (!v.early) begin
      for (int unsigned s = 0; s < v.stall; s++) begin
        chk("stall_hold", {out_valid, in_ready, p}, {1'b1, 1'b0, v.expv});
        @(posedge clk); #1; @(negedge clk);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk);
    end
    chk("done_ctl", {out_valid, in_ready, busy}, 3'b101);
    if (exp_q.size() != 0) want = exp_q.pop_front();
    else want = 'x;
    chk("product", p, want);
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("idle_after", {out_valid, in_ready, busy}, 3'b010);
    @(posedge clk); #1;
  endtask

  initial begin
    int unsigned    acc_cnt, k0, k1, cyc;
    bit             bad_ctl;
    logic [2*W-1:0] want;
    vec_t           v;

    tbl.push_back('{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0, 1'b0, 1'b0});
    tbl.push_back('{16'h1234, 16'h0000, 32'h00000000, 1, 1'b0, 1'b0});
    tbl.push_back('{16'h00A5, 16'h3C00, 32'h0026AC00, 5, 1'b0, 1'b0});
    tbl.push_back('{16'h0000, 16'hABCD, 32'h00000000, 0, 1'b1, 1'b0});
    tbl.push_back('{16'hFFFF, 16'h0001, 32'h0000FFFF, 2, 1'b0, 1'b0});
    tbl.push_back('{16'h8000, 16'h0002, 32'h00010000, 0, 1'b1, 1'b0});
`ifdef VEDIC_SEQ_MUL_SIGNED_EN
    tbl.push_back('{16'h8000, 16'hFFFF, 32'h00008000, 1, 1'b0, 1'b1});
    tbl.push_back('{16'hFFFE, 16'h0003, 32'hFFFFFFFA, 0, 1'b0, 1'b1});
    tbl.push_back('{16'h8000, 16'h8000, 32'h40000000, 0, 1'b1, 1'b1});
`endif
    tbl.push_back('{16'h1234, 16'h5678, 32'h06260060, 0, 1'b0, 1'b0});

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_p", p, '0);
    @(posedge clk); #1;

    for (int unsigned t = 0; t < tbl.size(); t++) txn(tbl[t]);

    // Reset during RUN discards the transaction
    a = 16'h1111; b = 16'h2222; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("pre_rst_ready", in_ready, 1'b1);
    exp_q.push_back(umul(a, b));
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_ctl", {out_valid, in_ready, busy}, 3'b010);
    chk("rst_mid_p", p, '0);
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    bad_ctl = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid || !in_ready || busy) bad_ctl = 1'b1;
    end
    chk("rst_discard", bad_ctl, 1'b0);
    @(posedge clk); #1 out_ready = 1'b0;
    v = '{16'h0003, 16'h0005, 32'h0000000F, 0, 1'b0, 1'b0};
    txn(v);

    // in_valid held high: one capture per transaction, N*N+2 spacing
    a = 16'h0007; b = 16'h0009; in_valid = 1'b1; out_ready = 1'b1;
`ifdef VEDIC_SEQ_MUL_SIGNED_EN
    signed_op = 1'b0;
`endif
    acc_cnt = 0; k0 = 0; k1 = 0;
    for (int unsigned k = 0; k < 36; k++) begin
      @(negedge clk);
      if (in_valid && in_ready) begin
        if (acc_cnt == 0) k0 = k;
        else k1 = k;
        acc_cnt++;
        exp_q.push_back(32'd63);
      end
      if (out_valid) begin
        if (exp_q.size() != 0) want = exp_q.pop_front();
        else want = 'x;
        chk("cont_product", p, want);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("cont_captures", acc_cnt, 2);
    chk("cont_spacing", k1 - k0, NN + 2);
    chk("cont_drained", exp_q.size(), 0);
    cyc = 0;
    @(negedge clk);
    while (!in_ready && cyc < 100) begin
      @(posedge clk); cyc++; @(negedge clk);
    end
    chk("cont_idle", in_ready, 1'b1);
    @(posedge clk); #1;

    // Randomised transactions with random gaps and output back-pressure
    for (int unsigned t = 0; t < 150; t++) begin
      v.a     = W'($urandom);
      v.b     = W'($urandom);
      v.stall = $urandom_range(0, 3);
      v.early = 1'($urandom_range(0, 1));
      v.sgn   = 1'b0;
`ifdef VEDIC_SEQ_MUL_SIGNED_EN
      v.sgn   = 1'($urandom_range(0, 1));
`endif
      if (t % 10 == 0) v.b = '0;
      v.expv = v.sgn ? smul(v.a, v.b) : umul(v.a, v.b);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      txn(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
